regfile_scoreboard: RTL

Parametrised multi-port integer register file with a per-register busy scoreboard, the next-generation replacement for the single-write, dual-read `register_file` in the toy RISC-V core. It provides NR combinational read ports and NW synchronous write ports. Register 0 is hardwired to zero. Issue logic marks destination registers busy and writeback clears them, so the pipeline can detect RAW and WAW hazards without extra logic.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_wr_merge.sv | 29 ++
 rtl/regfile_scoreboard.sv | 133 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file with busy scoreboard.
package regfile_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int XLEN_DEF   = 32;

   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
   typedef logic [XLEN_DEF-1:0]   xword_t;

   localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_wr_merge.sv
// Resolves NW write ports against one address; the highest-index matching port wins.
module regfile_wr_merge
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int XLEN   = XLEN_DEF,
   parameter int NW     = 1
) (
   input  logic [NW-1:0]        we_i,
   input  logic [NW*ADDR_W-1:0] wa_i,
   input  logic [NW*XLEN-1:0]   wd_i,
   input  logic [ADDR_W-1:0]    addr_i,
   output logic                 hit_o,
   output logic [XLEN-1:0]      data_o
);

   // Ascending scan so later (higher-index) ports overwrite earlier matches.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      for (int i = 0; i < NW; i++) begin
         if (we_i[i] && (wa_i[i*ADDR_W +: ADDR_W] == addr_i)) begin
            hit_o  = 1'b1;
            data_o = wd_i[i*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file (x0 hardwired to zero) with a per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int XLEN   = XLEN_DEF,
   parameter int NR     = 2,
   parameter int NW     = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NW-1:0]        we_i,
   input  logic [NW*ADDR_W-1:0] wa_i,
   input  logic [NW*XLEN-1:0]   wd_i,
   input  logic [NR*ADDR_W-1:0] ra_i,
   output logic [NR*XLEN-1:0]   rd_o,
   output logic [NR-1:0]        rbusy_o,
   input  logic                 alloc_v_i,
   input  logic [ADDR_W-1:0]    alloc_a_i,
   output logic                 alloc_rdy_o,
   output logic [ADDR_W:0]      busy_cnt_o
);

   localparam int NREG = 1 << ADDR_W;
   localparam int CW   = ADDR_W + 1;

   logic [XLEN-1:0] mem_q [1:NREG-1];
   logic [NREG-1:1] busy_q, busy_d;
   logic [CW-1:0]   busyCnt_q, busyCnt_d;
   logic [NREG-1:1] wrHit;
   logic [XLEN-1:0] wrData [1:NREG-1];
   logic [XLEN-1:0] memView [NREG];
   logic [NREG-1:0] busyView;
   logic            allocAccept;

   for (genvar a = 1; a < NREG; a++) begin : g_wr
      regfile_wr_merge #(.ADDR_W(ADDR_W), .XLEN(XLEN), .NW(NW)) u_merge (
         .we_i   (we_i),
         .wa_i   (wa_i),
         .wd_i   (wd_i),
         .addr_i (ADDR_W'(a)),
         .hit_o  (wrHit[a]),
         .data_o (wrData[a])
      );
   end

   // Register 0 appears as a constant zero, not busy, so reads need no special case.
   always_comb begin
      memView[0]  = '0;
      busyView[0] = 1'b0;
      for (int a = 1; a < NREG; a++) begin
         memView[a]  = mem_q[a];
         busyView[a] = busy_q[a];
      end
   end

   assign alloc_rdy_o = (alloc_a_i == '0) | ~busyView[alloc_a_i];
   assign allocAccept = alloc_v_i & alloc_rdy_o;

   // Set beats clear; an accepted allocation always targets a non-busy register,
   // so the counter tracks exactly the number of busy bits.
   always_comb begin
      busy_d    = busy_q;
      busyCnt_d = busyCnt_q;
      for (int a = 1; a < NREG; a++) begin
         if (wrHit[a]) begin
            busy_d[a] = 1'b0;
            if (busy_q[a]) busyCnt_d = busyCnt_d - CW'(1);
         end
         if (allocAccept && (alloc_a_i == ADDR_W'(a))) begin
            busy_d[a] = 1'b1;
            busyCnt_d = busyCnt_d + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int a = 1; a < NREG; a++) mem_q[a] <= '0;
         busy_q    <= '0;
         busyCnt_q <= '0;
      end else begin
         for (int a = 1; a < NREG; a++) begin
            if (wrHit[a]) mem_q[a] <= wrData[a];
         end
         busy_q    <= busy_d;
         busyCnt_q <= busyCnt_d;
      end
   end

   assign busy_cnt_o = busyCnt_q;

`ifdef RF_BYPASS_EN
   logic [NR-1:0]   rdHit;
   logic [XLEN-1:0] rdData [NR];

   for (genvar j = 0; j < NR; j++) begin : g_byp
      regfile_wr_merge #(.ADDR_W(ADDR_W), .XLEN(XLEN), .NW(NW)) u_merge (
         .we_i   (we_i),
         .wa_i   (wa_i),
         .wd_i   (wd_i),
         .addr_i (ra_i[j*ADDR_W +: ADDR_W]),
         .hit_o  (rdHit[j]),
         .data_o (rdData[j])
      );
   end

   always_comb begin
      rd_o    = '0;
      rbusy_o = '0;
      for (int j = 0; j < NR; j++) begin
         if (rdHit[j] && (ra_i[j*ADDR_W +: ADDR_W] != '0)) begin
            rd_o[j*XLEN +: XLEN] = rdData[j];
            rbusy_o[j]           = 1'b0;
         end else begin
            rd_o[j*XLEN +: XLEN] = memView[ra_i[j*ADDR_W +: ADDR_W]];
            rbusy_o[j]           = busyView[ra_i[j*ADDR_W +: ADDR_W]];
         end
      end
   end
`else
   always_comb begin
      rd_o    = '0;
      rbusy_o = '0;
      for (int j = 0; j < NR; j++) begin
         rd_o[j*XLEN +: XLEN] = memView[ra_i[j*ADDR_W +: ADDR_W]];
         rbusy_o[j]           = busyView[ra_i[j*ADDR_W +: ADDR_W]];
      end
   end
`endif

endmodule
